// File: rtl/multi_chan_counter_pkg.sv
// Shared types and the next-count helper for the multi-channel counter bank.
package multi_chan_counter_pkg;

    // Widest counter the helper function supports.
    localparam int unsigned MAX_W = 64;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    typedef logic [MAX_W-1:0] cnt_t;

    // Result of one counting step: the new value and whether a limit was crossed.
    typedef struct packed {
        cnt_t next;
        logic hit_limit;
    } next_t;

    // Read response payload.
    typedef struct packed {
        cnt_t data;
        logic wrap;
        logic err;
    } rsp_t;

    // One up/down step of a width-bit counter. Counting at a limit always
    // reports hit_limit. The value then wraps or sticks according to saturate.
    function automatic next_t next_count(input cnt_t        count,
                                         input dir_e        dir,
                                         input logic        saturate,
                                         input int unsigned width);
        next_t res;
        cnt_t  max_v;
        if (width >= MAX_W) begin
            max_v = '1;
        end else begin
            max_v = (cnt_t'(1) << width) - cnt_t'(1);
        end
        res.hit_limit = 1'b0;
        res.next      = count;
        if (dir == DIR_UP) begin
            if (count == max_v) begin
                res.hit_limit = 1'b1;
                res.next      = saturate ? max_v : '0;
            end else begin
                res.next = count + cnt_t'(1);
            end
        end else begin
            if (count == '0) begin
                res.hit_limit = 1'b1;
                res.next      = saturate ? '0 : max_v;
            end else begin
                res.next = count - cnt_t'(1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_chan_counter_chan.sv
// One counter channel: the count register, the sticky wrap flag and the
// load > clear > count > disable priority chain.
module counter_chan
    import multi_chan_counter_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SATURATE       = 0,
    parameter int CLR_ON_DISABLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_dir,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    input  logic             i_flag_clr,
    output logic [WIDTH-1:0] o_count,
    output logic             o_wrap_flag
);

    logic [WIDTH-1:0] r_count;
    logic             r_flag;
    next_t            w_step;
    logic [WIDTH-1:0] w_count_d;
    logic             w_flag_set;
    logic             w_flag_d;
    logic             w_unused_step;

    assign w_step        = next_count(cnt_t'(r_count), dir_e'(i_dir), (SATURATE != 0), WIDTH);
    assign w_unused_step = ^w_step.next;

    // Next count by priority; only an actual count step can raise the flag.
    always_comb begin
        w_count_d  = r_count;
        w_flag_set = 1'b0;
        if (i_load) begin
            w_count_d = i_load_value;
        end else if (i_clr) begin
            w_count_d = '0;
        end else if (i_enable) begin
            w_count_d  = w_step.next[WIDTH-1:0];
            w_flag_set = w_step.hit_limit;
        end else if (CLR_ON_DISABLE != 0) begin
            w_count_d = '0;
        end else begin
            w_count_d = r_count;
        end
    end

    // Sticky flag: a new limit crossing beats a read-to-clear in the same cycle.
    always_comb begin
        w_flag_d = r_flag;
        if (w_flag_set) begin
            w_flag_d = 1'b1;
        end else if (i_flag_clr) begin
            w_flag_d = 1'b0;
        end else begin
            w_flag_d = r_flag;
        end
    end

    // Count and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_flag  <= 1'b0;
        end else begin
            r_count <= w_count_d;
            r_flag  <= w_flag_d;
        end
    end

    assign o_count     = r_count;
    assign o_wrap_flag = r_flag;

endmodule

// File: rtl/multi_chan_counter.sv
// Bank of NUM_CH independent counters with a valid/ready read port and a
// single-entry, back-pressurable response register.
module multi_chan_counter
    import multi_chan_counter_pkg::*;
#(
    parameter int NUM_CH         = 4,
    parameter int WIDTH          = 8,
    parameter int SATURATE       = 0,
    parameter int CLR_ON_DISABLE = 1,
    localparam int CH_W          = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH-1:0]       dir,
    input  logic [NUM_CH-1:0]       clr,
    input  logic                    load_en,
    input  logic [CH_W-1:0]         load_ch,
    input  logic [WIDTH-1:0]        load_value,
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       wrap_flag,
    input  logic                    rd_valid,
    input  logic [CH_W-1:0]         rd_ch,
    output logic                    rd_ready,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_wrap,
    output logic                    rsp_err
);

    logic [WIDTH-1:0]  w_chan_count [NUM_CH];
    logic [NUM_CH-1:0] w_chan_wrap;
    logic [NUM_CH-1:0] w_load_hit;
    logic [NUM_CH-1:0] w_flag_clr;
    logic              w_rd_accept;
    logic              w_rd_in_range;
    rsp_t              w_sel;
    rsp_t              r_rsp;
    logic              r_rsp_valid;
    logic              w_unused_rsp;

    // The output register can take a new entry when empty or being drained.
    assign rd_ready      = !r_rsp_valid || rsp_ready;
    assign w_rd_accept   = rd_valid && rd_ready;
    assign w_rd_in_range = ({1'b0, rd_ch} < (CH_W+1)'(NUM_CH));

    // Decode load/read channel indices and select the pre-edge snapshot.
    // Out-of-range indices match no channel, so they neither load nor clear.
    always_comb begin
        w_load_hit = '0;
        w_flag_clr = '0;
        w_sel      = '0;
        w_sel.err  = !w_rd_in_range;
        for (int i = 0; i < NUM_CH; i++) begin
            if (load_en && (load_ch == CH_W'(i))) begin
                w_load_hit[i] = 1'b1;
            end else begin
                w_load_hit[i] = 1'b0;
            end
            if (rd_ch == CH_W'(i)) begin
                w_sel.data    = cnt_t'(w_chan_count[i]);
                w_sel.wrap    = w_chan_wrap[i];
                w_flag_clr[i] = w_rd_accept;
            end else begin
                w_flag_clr[i] = 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        counter_chan #(
            .WIDTH          (WIDTH),
            .SATURATE       (SATURATE),
            .CLR_ON_DISABLE (CLR_ON_DISABLE)
        ) u_chan (
            .clk          (clk),
            .rst          (rst),
            .i_enable     (enable[g]),
            .i_dir        (dir[g]),
            .i_clr        (clr[g]),
            .i_load       (w_load_hit[g]),
            .i_load_value (load_value),
            .i_flag_clr   (w_flag_clr[g]),
            .o_count      (w_chan_count[g]),
            .o_wrap_flag  (w_chan_wrap[g])
        );
        assign count[g*WIDTH +: WIDTH] = w_chan_count[g];
    end

    assign wrap_flag = w_chan_wrap;

    // Response register: load on accept, clear once consumed, hold while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else if (w_rd_accept) begin
            r_rsp_valid <= 1'b1;
            r_rsp       <= w_sel;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp       <= '0;
        end else begin
            r_rsp_valid <= r_rsp_valid;
            r_rsp       <= r_rsp;
        end
    end

    assign w_unused_rsp = ^r_rsp.data;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp.data[WIDTH-1:0];
    assign rsp_wrap     = r_rsp.wrap;
    assign rsp_err      = r_rsp.err;

endmodule
